// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg
// Shared definitions for the front-panel time-setting controller.
//   SELECT_* : field codes driven on `select` and decoded by the
//              time-keeping and alarm blocks.
//   next_select : mode-button field rotation NONE->SEC->MIN->HOUR->NONE.
package time_set_ctrl_pkg;

  localparam logic [1:0] SELECT_NONE = 2'd0;
  localparam logic [1:0] SELECT_SEC  = 2'd1;
  localparam logic [1:0] SELECT_MIN  = 2'd2;
  localparam logic [1:0] SELECT_HOUR = 2'd3;

  function automatic logic [1:0] next_select(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      SELECT_NONE: nxt = SELECT_SEC;
      SELECT_SEC:  nxt = SELECT_MIN;
      SELECT_MIN:  nxt = SELECT_HOUR;
      default:     nxt = SELECT_NONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/time_set_ctrl_debouncer.sv
// debouncer
// Two-flop synchronizer followed by a stability counter. The debounced
// level follows the synchronized input only after the two have differed
// for CYCLES consecutive cycles; any return to agreement restarts the count.
// Raw edge to debounced edge latency is 2 + CYCLES cycles.
// Ports:
//   clk     in  : system clock
//   reset_n in  : synchronous active-low reset
//   raw     in  : asynchronous button input, active-high
//   level   out : debounced level
module debouncer #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        // This cycle is the CYCLES-th consecutive disagreement.
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Front-panel setting controller: turns the raw mode and increment buttons
// into the select/increment field-setting interface.
// Optional feature: define TIME_SET_AUTO_REPEAT_EN to enable hold-to-repeat
// increment pulses; without it exactly one pulse is issued per press.
// Ports:
//   clk       in      : system clock (single domain)
//   reset_n   in      : synchronous active-low reset
//   btn_mode  in      : raw mode button, active-high
//   btn_inc   in      : raw increment button, active-high
//   select    out [2] : field under edit (SELECT_* codes)
//   increment out     : single-cycle increment pulse
//   setting   out     : high whenever select != SELECT_NONE
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] select,
  output logic       increment,
  output logic       setting
);

  // Repeat period below 2 would merge consecutive pulses.
  if (REPEAT_CYCLES < 2 || HOLD_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("time_set_ctrl: invalid cycle parameters");
  end

  typedef enum logic [1:0] {
    INC_IDLE         = 2'd0,
    INC_WAIT_RELEASE = 2'd1
`ifdef TIME_SET_AUTO_REPEAT_EN
    ,
    INC_HOLD         = 2'd2,
    INC_REPEAT       = 2'd3
`endif
  } inc_state_t;

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic mode_level, inc_level;
  logic mode_prev, inc_prev;
  logic mode_press, inc_press, any_press;
  logic timeout_hit;

  logic [1:0]      select_next;
  logic [TO_W-1:0] to_cnt, to_next;
  inc_state_t      state, state_next;
  logic            inc_next;

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int unsigned RC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RC_W   = $clog2(RC_MAX + 1);
  logic [RC_W-1:0] rep_cnt, rep_next;
`endif

  debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_mode),
    .level   (mode_level)
  );

  debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_inc),
    .level   (inc_level)
  );

  assign mode_press = mode_level & ~mode_prev;
  assign inc_press  = inc_level & ~inc_prev;
  assign any_press  = mode_press | inc_press;

  // A press or a held inc button in the same cycle keeps setting mode alive.
  assign timeout_hit = (select != SELECT_NONE) && !inc_level && !any_press &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    select_next = select;
    if (mode_press) begin
      select_next = next_select(select);
    end else if (timeout_hit) begin
      select_next = SELECT_NONE;
    end
  end

  always_comb begin
    to_next = to_cnt;
    if (any_press || inc_level || timeout_hit || select == SELECT_NONE) begin
      to_next = '0;
    end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      to_next = to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    inc_next   = 1'b0;
`ifdef TIME_SET_AUTO_REPEAT_EN
    rep_next   = rep_cnt;
`endif
    if (timeout_hit) begin
      state_next = INC_IDLE;
    end else begin
      case (state)
        INC_IDLE: begin
          if (inc_press) begin
            // Mode wins a simultaneous press; NONE has no field to bump.
            if (mode_press || select == SELECT_NONE) begin
              state_next = INC_WAIT_RELEASE;
            end else begin
              inc_next = 1'b1;
`ifdef TIME_SET_AUTO_REPEAT_EN
              state_next = INC_HOLD;
              rep_next   = '0;
`else
              state_next = INC_WAIT_RELEASE;
`endif
            end
          end
        end
`ifdef TIME_SET_AUTO_REPEAT_EN
        INC_HOLD: begin
          if (!inc_level) begin
            state_next = INC_IDLE;
          end else if (mode_press) begin
            state_next = INC_WAIT_RELEASE;
          end else if (rep_cnt == RC_W'(HOLD_CYCLES - 1)) begin
            inc_next   = 1'b1;
            state_next = INC_REPEAT;
            rep_next   = '0;
          end else begin
            rep_next = rep_cnt + 1'b1;
          end
        end
        INC_REPEAT: begin
          if (!inc_level) begin
            state_next = INC_IDLE;
          end else if (mode_press) begin
            state_next = INC_WAIT_RELEASE;
          end else if (rep_cnt == RC_W'(REPEAT_CYCLES - 1)) begin
            inc_next = 1'b1;
            rep_next = '0;
          end else begin
            rep_next = rep_cnt + 1'b1;
          end
        end
`endif
        INC_WAIT_RELEASE: begin
          if (!inc_level) begin
            state_next = INC_IDLE;
          end
        end
        default: state_next = INC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
      select    <= SELECT_NONE;
      setting   <= 1'b0;
      increment <= 1'b0;
      to_cnt    <= '0;
      state     <= INC_IDLE;
`ifdef TIME_SET_AUTO_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      mode_prev <= mode_level;
      inc_prev  <= inc_level;
      select    <= select_next;
      setting   <= (select_next != SELECT_NONE);
      increment <= inc_next;
      to_cnt    <= to_next;
      state     <= state_next;
`ifdef TIME_SET_AUTO_REPEAT_EN
      rep_cnt   <= rep_next;
`endif
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl
// Directed bench for time_set_ctrl with DEBOUNCE=4, HOLD=20, REPEAT=5,
// TIMEOUT=100. Raw edge to select/increment update is 7 cycles.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] select;
  logic       increment;
  logic       setting;

  int checks = 0;
  int errors = 0;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (5),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .select    (select),
    .increment (increment),
    .setting   (setting)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic mode_press();
    btn_mode = 1'b1;
    tick(8);
    btn_mode = 1'b0;
    tick(8);
  endtask

`ifdef TIME_SET_AUTO_REPEAT_EN
  int exp_t[5] = '{7, 27, 32, 37, 42};
`else
  int exp_t[1] = '{7};
`endif

  initial begin
    int q[$];
    int pulses;
    int found;
    logic [1:0] exp_sel[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_set[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    reset_n  = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(3);
    check("reset_select", select, 0);
    check("reset_increment", increment, 0);
    check("reset_setting", setting, 0);
    reset_n = 1'b1;
    tick(2);

    // Field rotation.
    for (int i = 0; i < 4; i++) begin
      mode_press();
      check("rot_select", select, exp_sel[i]);
      check("rot_setting", setting, exp_set[i]);
    end
    check("rot_no_inc", increment, 0);

    // Short glitches must not register.
    for (int i = 0; i < 3; i++) begin
      btn_mode = 1'b1;
      tick(3);
      btn_mode = 1'b0;
      tick(3);
    end
    tick(8);
    check("glitch_select", select, 0);

    // Clean 10-cycle press: update lands on the 7th edge.
    btn_mode = 1'b1;
    tick(6);
    check("latency_before", select, 0);
    tick(1);
    check("latency_after", select, 1);
    tick(3);
    btn_mode = 1'b0;
    tick(10);

    mode_press();
    check("to_min", select, 2);

    // Inc held 40 cycles on MIN.
    btn_inc = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      if (increment) q.push_back(k);
      if (k == 40) btn_inc = 1'b0;
    end
    check("hold_pulse_count", q.size(), $size(exp_t));
    for (int i = 0; i < $size(exp_t); i++) begin
      if (i < q.size()) check("hold_pulse_time", q[i], exp_t[i]);
    end
    check("hold_select", select, 2);

    // Timeout from HOUR: exactly 100 cycles after the press takes effect.
    btn_mode = 1'b1;
    tick(7);
    check("to_hour", select, 3);
    btn_mode = 1'b0;
    tick(99);
    check("timeout_before", select, 3);
    tick(1);
    check("timeout_select", select, 0);
    check("timeout_setting", setting, 0);

    // Inc press with no field selected.
    pulses = 0;
    btn_inc = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (increment) pulses++;
    end
    btn_inc = 1'b0;
    tick(10);
    check("none_no_pulse", pulses, 0);

    // Simultaneous mode+inc from NONE: mode wins, no pulse while held.
    pulses = 0;
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (increment) pulses++;
      if (k == 7) check("simul_select", select, 1);
      if (k == 10) btn_mode = 1'b0;
    end
    btn_inc = 1'b0;
    tick(10);
    check("simul_no_pulse", pulses, 0);

    // Fresh inc press gives the pulse; hold past the timeout.
    btn_inc = 1'b1;
    tick(6);
    check("repress_before", increment, 0);
    tick(1);
    check("repress_pulse", increment, 1);
    tick(150);
    check("held_no_timeout", select, 1);
    check("held_setting", setting, 1);

`ifdef TIME_SET_AUTO_REPEAT_EN
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick(1);
      if (increment) found = 1;
    end
    check("repeat_pulse_seen", found, 1);
`endif
    reset_n = 1'b0;
    tick(1);
    check("rst_increment", increment, 0);
    check("rst_select", select, 0);
    check("rst_setting", setting, 0);
    reset_n = 1'b1;

    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (increment) pulses++;
    end
    check("post_rst_no_pulse", pulses, 0);
    btn_inc = 1'b0;
    tick(10);

    mode_press();
    check("post_rst_mode", select, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
